// File: rtl/mod12_pkg.sv
// ============================================================================
// Module   : mod12_pkg
// Purpose  : Shared defaults, state type and terminal constant for the
//            mod-12 counter family.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mod12_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_MOD   = 12;

    // Largest legal count; also the reset value of the reload register.
    localparam logic [DEF_WIDTH-1:0] MOD_MAX = DEF_WIDTH'(DEF_MOD - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage : mod12_pkg

`default_nettype wire

// File: rtl/sync_4bit_mod12_loadable_down_counter.sv
// ============================================================================
// Module   : sync_4bit_mod12_loadable_down_counter
// Purpose  : Loadable mod-MOD down counter with borrow, terminal count and
//            out-of-range load flag. Define MOD12_AUTORELOAD_EN to make a
//            wrap restore the last loaded value instead of MOD-1.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_4bit_mod12_loadable_down_counter
    import mod12_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int MOD   = DEF_MOD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic             load_en,
    input  logic             cnt_en,
    output logic [WIDTH-1:0] q,
    output logic             borrow,
    output logic             tc,
    output logic             load_err
);

    // One extra bit so MOD == 2**WIDTH still compares correctly.
    localparam logic [WIDTH:0]   C_MOD_EXT = (WIDTH+1)'(MOD);
    localparam logic [WIDTH-1:0] C_MAX     = WIDTH'(MOD - 1);

    state_t           state_q,    state_d;
    logic [WIDTH-1:0] cnt_q,      cnt_d;
    logic [WIDTH-1:0] reload_q,   reload_d;
    logic             borrow_q,   borrow_d;
    logic             load_err_q, load_err_d;

    logic             w_data_ok;
    logic [WIDTH-1:0] w_wrap_val;

    assign w_data_ok = ({1'b0, data} < C_MOD_EXT);

`ifdef MOD12_AUTORELOAD_EN
    assign w_wrap_val = reload_q;
`else
    assign w_wrap_val = C_MAX;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        reload_d   = reload_q;
        borrow_d   = 1'b0;
        load_err_d = 1'b0;

        if (load_en) begin
            state_d = RUN;
            if (w_data_ok) begin
                cnt_d    = data;
                reload_d = data;
            end else begin
                cnt_d      = C_MAX;
                reload_d   = C_MAX;
                load_err_d = 1'b1;
            end
        end else if ((state_q == RUN) && cnt_en) begin
            if (cnt_q == '0) begin
                cnt_d    = w_wrap_val;
                borrow_d = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            reload_q   <= C_MAX;
            borrow_q   <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            reload_q   <= reload_d;
            borrow_q   <= borrow_d;
            load_err_q <= load_err_d;
        end
    end

    assign q        = cnt_q;
    assign borrow   = borrow_q;
    assign load_err = load_err_q;
    assign tc       = (state_q == RUN) && (cnt_q == '0);

endmodule : sync_4bit_mod12_loadable_down_counter

`default_nettype wire

// File: tb/tb_sync_4bit_mod12_loadable_down_counter.sv
// ============================================================================
// Module   : tb_sync_4bit_mod12_loadable_down_counter
// Purpose  : Directed and random checks of the mod-12 down counter against
//            a behavioural model (honours MOD12_AUTORELOAD_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sync_4bit_mod12_loadable_down_counter;
    import mod12_pkg::*;

    localparam int MODV = DEF_MOD;
`ifdef MOD12_AUTORELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] data = '0;
    logic       load_en = 1'b0;
    logic       cnt_en = 1'b0;
    logic [3:0] q;
    logic       borrow, tc, load_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    int m_q, m_reload;
    bit m_run, m_borrow, m_err;

    sync_4bit_mod12_loadable_down_counter dut (
        .clk      (clk),
        .rst      (rst),
        .data     (data),
        .load_en  (load_en),
        .cnt_en   (cnt_en),
        .q        (q),
        .borrow   (borrow),
        .tc       (tc),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q = 0; m_reload = MODV - 1; m_run = 0; m_borrow = 0; m_err = 0;
    endtask

    task automatic model_step(input bit l, input int d, input bit c);
        m_borrow = 0;
        m_err    = 0;
        if (l) begin
            m_run    = 1;
            m_err    = (d >= MODV);
            m_q      = m_err ? MODV - 1 : d;
            m_reload = m_q;
        end else if (m_run && c) begin
            m_borrow = (m_q == 0);
            if (m_borrow && AUTO) m_q = m_reload;
            else                  m_q = (m_q + MODV - 1) % MODV;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_q"},        16'(q),        16'(m_q));
        chk({tag, "_borrow"},   16'(borrow),   16'(m_borrow));
        chk({tag, "_load_err"}, 16'(load_err), 16'(m_err));
        chk({tag, "_tc"},       16'(tc),       16'(m_run && (m_q == 0)));
    endtask

    // Drive at the falling edge, let the rising edge act, check at the next fall.
    task automatic cycle(input bit l, input int d, input bit c, input string tag);
        load_en = l;
        data    = 4'(d);
        cnt_en  = c;
        @(posedge clk);
        model_step(l, d, c);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b0;
        #1 model_reset();
        check_all({tag, "_now"});
        @(negedge clk);
        rst = 1'b1;
        check_all({tag, "_held"});
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        check_all("reset");
        rst = 1'b1;

        // Counting is ignored before the first load
        for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b1, "idle_cnt");
        chk("idle_q_const", 16'(q), 16'd0);

        // Load 5 and count through a wrap
        cycle(1'b1, 5, 1'b0, "ld5");
        chk("ld5_q_const", 16'(q), 16'd5);
        for (int i = 1; i <= 5; i++) begin
            cycle(1'b0, 0, 1'b1, "dn5");
            chk("dn5_q_const", 16'(q), 16'(5 - i));
        end
        chk("dn5_tc_const", 16'(tc), 16'd1);
        cycle(1'b0, 0, 1'b1, "wrap5");
        chk("wrap5_q_const", 16'(q), AUTO ? 16'd5 : 16'(MOD_MAX));
        chk("wrap5_borrow_const", 16'(borrow), 16'd1);
        cycle(1'b0, 0, 1'b1, "post_wrap5");
        chk("post_wrap5_borrow_const", 16'(borrow), 16'd0);

        // Out-of-range load clamps to MOD-1 and flags once
        cycle(1'b1, 14, 1'b0, "ld14");
        chk("ld14_q_const", 16'(q), 16'd11);
        chk("ld14_err_const", 16'(load_err), 16'd1);
        for (int i = 0; i < 12; i++) cycle(1'b0, 0, 1'b1, "dn14");
        chk("wrap14_q_const", 16'(q), 16'd11);
        for (int i = 0; i < 11; i++) cycle(1'b0, 0, 1'b1, "to_zero");
        chk("zero_q_const", 16'(q), 16'd0);

        // Load beats a simultaneous wrap
        cycle(1'b1, 3, 1'b1, "ld_vs_wrap");
        chk("ld_vs_wrap_q_const", 16'(q), 16'd3);
        chk("ld_vs_wrap_borrow_const", 16'(borrow), 16'd0);

        // Asynchronous reset mid-count
        cycle(1'b1, 8, 1'b0, "ld8");
        cycle(1'b0, 0, 1'b1, "dn8");
        cycle(1'b0, 0, 1'b1, "dn8");
        chk("dn8_q_const", 16'(q), 16'd6);
        async_reset("rst_mid");
        for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b1, "post_rst_cnt");
        chk("post_rst_q_const", 16'(q), 16'd0);

        // Hold with cnt_en low
        cycle(1'b1, 4, 1'b0, "ld4");
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 0, 1'b0, "hold4");
            chk("hold4_q_const", 16'(q), 16'd4);
        end

        // Random traffic including occasional asynchronous resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 3) async_reset("rnd_rst");
            else cycle($urandom_range(0, 7) == 0, int'($urandom_range(0, 15)),
                       $urandom_range(0, 3) != 0, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sync_4bit_mod12_loadable_down_counter

`default_nettype wire

// File: doc/sync_4bit_mod12_loadable_down_counter.md
# sync_4bit_mod12_loadable_down_counter

Loadable synchronous mod-12 down counter; the count-down counterpart of the team's mod-12 loadable up counter. Used wherever a value must be preset and then decremented to a terminal count, e.g. a countdown digit or a period timer. It raises a borrow pulse on wrap so digits can be cascaded, and flags out-of-range preset values instead of silently loading them.

## Interface
- WIDTH, 4: counter width in bits.
- MOD, 12: modulus; legal count range 0..MOD-1. Constraint: 2 ≤ MOD ≤ 2^WIDTH.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- data  input  WIDTH  preset value, sampled when load_en=1.
- load_en  input  1  synchronous load request.
- cnt_en  input  1  decrement enable.
- q  output  WIDTH  current count, registered.
- borrow  output  1  registered one-cycle pulse on wrap (q 0 → next value).
- tc  output  1  combinational terminal count: state==RUN and q==0.
- load_err  output  1  registered one-cycle pulse after an out-of-range load.

## Operation
- States: IDLE, RUN.
- In IDLE, q holds 0 and cnt_en is ignored. Any load, valid or not, moves the FSM to RUN.
- RUN persists until reset.
- Priority per edge: rst > load_en > cnt_en.
- Valid load (data < MOD):
  - q ← data, reload ← data, load_err ← 0.
- Invalid load (data ≥ MOD):
  - q ← MOD-1, reload ← MOD-1, load_err ← 1.
- Decrement (RUN, cnt_en=1, load_en=0, q>0): q ← q-1, borrow ← 0.
- Wrap (RUN, cnt_en=1, load_en=0, q==0): borrow ← 1, next q per Configuration.
- A load in the same cycle as a wrap condition: load wins and borrow ← 0.
- cnt_en=0 in RUN: q holds, borrow ← 0.
- load_err and borrow clear to 0 on every edge where their set condition is absent.
- q never leaves 0..MOD-1.
- Arithmetic is unsigned, WIDTH bits, with no intermediate overflow.

## Timing
- Reset (rst=0, asynchronous): q=0, borrow=0, load_err=0, reload=MOD-1, state=IDLE, tc=0.
- Reset asserted mid-count takes effect immediately, without waiting for a clock edge.
- First action after reset deassertion is on the next rising edge.
- Load latency: q shows the preset value 1 cycle after the sampling edge. load_err is aligned with that same cycle.
- Decrement latency: 1 cycle.
- borrow is high in the cycle in which q shows the post-wrap value.
- tc is high in every RUN cycle where q==0, independent of cnt_en.
- No handshake; inputs are sampled every edge and must meet setup to clk.

## Configuration
- MOD12_AUTORELOAD_EN defined: a wrap sets q ← reload, the last loaded value (MOD-1 if none was loaded since reset).
- Not defined: a wrap sets q ← MOD-1 (plain mod-MOD down count).
- The reload register is kept in both builds; it is simply unused when the macro is absent.

## Structure
- Shared package mod12_pkg holds:
  - WIDTH and MOD defaults.
  - The state typedef (IDLE, RUN).
  - The constant MOD-1.
- Single module; no sub-module. The range check and next-state logic are small enough to stay inline.

## Test plan
- Reset, then cnt_en=1 for 3 cycles with no load -> q stays 0, tc=0, borrow=0.
- Load data=5, then cnt_en=1 for 7 cycles:
  - q follows 5,4,3,2,1,0, then wraps.
  - Wrap value is 11 without the macro and 5 with MOD12_AUTORELOAD_EN.
  - borrow=1 for exactly the wrap cycle; tc=1 while q=0.
- Load data=14 -> q=11, load_err=1 for one cycle.
  - Then cnt_en, with the macro defined: the wrap reloads 11.
- Assert load_en with data=3 and cnt_en=1 while q=0 -> q=3, borrow=0.
- Load 8, count to 6, then pull rst low between edges:
  - q=0, state IDLE immediately.
  - After release, cnt_en is ignored until the next load.
- cnt_en held 0 in RUN with q=4 for 5 cycles -> q=4 throughout, borrow=0, tc=0.
